// File: rtl/delta_neuron_scheduler.sv
// Delta-reporting LIF neuron scheduler: N_NEUR virtual neurons share one
// leak/integrate/fire datapath and raise events only on significant change.
module delta_neuron_scheduler #(
  parameter int N_NEUR     = 4,
  parameter int LEAK_SHIFT = 1,
  parameter int V_TH       = 200,
  parameter int DELTA_TH   = 50,
  localparam int IW = (N_NEUR > 1) ? $clog2(N_NEUR) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          cur_we,
  input  logic [IW-1:0] cur_idx,
  input  logic [7:0]    cur_data,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [IW-1:0] evt_idx,
  output logic [7:0]    evt_delta,
  output logic          evt_up,
  output logic          evt_spike,
  output logic          busy,
  output logic          overrun
);

  localparam logic [7:0]    V_TH8   = 8'(V_TH);
  localparam logic [7:0]    DTH8    = 8'(DELTA_TH);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_NEUR - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UPD  = 2'd1,
    CMP  = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [7:0]    cur_mem  [N_NEUR];
  logic [7:0]    u_mem    [N_NEUR];
  logic [7:0]    last_mem [N_NEUR];
  logic          spike;

  logic [7:0]    u_sel, last_sel, leak, sum_sat, diff;
  logic [8:0]    sum;
  logic          fire, up, need_emit;

  // Shared datapath for the neuron at idx; u_mem already holds u_new in CMP.
  always_comb begin
    u_sel     = u_mem[idx];
    last_sel  = last_mem[idx];
    leak      = u_sel >> LEAK_SHIFT;
    sum       = {1'b0, u_sel} - {1'b0, leak} + {1'b0, cur_mem[idx]};
    sum_sat   = sum[8] ? 8'hFF : sum[7:0];
    fire      = (sum_sat >= V_TH8);
    up        = (u_sel > last_sel);
    diff      = up ? (u_sel - last_sel) : (last_sel - u_sel);
    need_emit = (diff >= DTH8) || spike;
  end

  // Next-state and neuron index sequencing.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nx = UPD;
          idx_nx   = {IW{1'b0}};
        end else begin
          state_nx = IDLE;
        end
      end
      UPD: begin
        state_nx = CMP;
      end
      CMP, EMIT: begin
        if ((state == CMP && need_emit) || (state == EMIT && !evt_ready)) begin
          state_nx = EMIT;
        end else if (idx == IDX_MAX) begin
          state_nx = IDLE;
        end else begin
          state_nx = UPD;
          idx_nx   = idx + IW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = {IW{1'b0}};
      end
    endcase
  end

  // State, neuron memories and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= {IW{1'b0}};
      spike     <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      evt_valid <= 1'b0;
      evt_idx   <= {IW{1'b0}};
      evt_delta <= 8'd0;
      evt_up    <= 1'b0;
      evt_spike <= 1'b0;
      for (int i = 0; i < N_NEUR; i++) begin
        cur_mem[i]  <= 8'd0;
        u_mem[i]    <= 8'd0;
        last_mem[i] <= 8'd0;
      end
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      busy  <= (state_nx != IDLE);
      if (cur_we) begin
        cur_mem[cur_idx] <= cur_data;
      end
      if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        UPD: begin
          u_mem[idx] <= fire ? 8'd0 : sum_sat;
          spike      <= fire;
        end
        CMP: begin
          if (need_emit) begin
            evt_valid <= 1'b1;
            evt_idx   <= idx;
            evt_delta <= diff;
            evt_up    <= up;
            evt_spike <= spike;
          end
        end
        EMIT: begin
          if (evt_ready) begin
            last_mem[idx] <= u_mem[idx];
            evt_valid     <= 1'b0;
            evt_idx       <= {IW{1'b0}};
            evt_delta     <= 8'd0;
            evt_up        <= 1'b0;
            evt_spike     <= 1'b0;
          end
        end
        default: begin
          spike <= spike;
        end
      endcase
    end
  end

endmodule

// File: doc/delta_neuron_scheduler.md
DELTA_NEURON_SCHEDULER -- requirements
Module: delta_neuron_scheduler

Interface
REQ-001 SHALL have parameter N_NEUR, default 4: number of time-multiplexed virtual neurons sharing one LIF update datapath.
REQ-002 SHALL have parameter LEAK_SHIFT, default 1: leak = u >> LEAK_SHIFT.
REQ-003 SHALL have parameter V_TH, default 200: membrane spike threshold (8-bit).
REQ-004 SHALL have parameter DELTA_TH, default 50: delta-report threshold (8-bit).
REQ-005 SHALL have ports in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle sweep request.
- cur_we  in  1  current write strobe.
- cur_idx  in  log2(N_NEUR)  neuron addressed by the write.
- cur_data  in  8  unsigned input current.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_idx  out  log2(N_NEUR)  neuron index of the event.
- evt_delta  out  8  |u_new - last_reported|.
- evt_up  out  1  1 if u_new > last_reported.
- evt_spike  out  1  neuron fired in this update.
- busy  out  1  sweep in progress.
- overrun  out  1  sticky: a tick arrived while busy.
REQ-006 SHALL use one clock and a synchronous, active-high reset named rst; there SHALL be no asynchronous logic.

Function
REQ-007 SHALL hold per neuron: cur[i], u[i] and last[i], each 8 bits.
REQ-008 SHALL write cur[cur_idx] <= cur_data at the edge where cur_we=1, in any state; cur values persist until overwritten.
REQ-009 SHALL implement FSM states IDLE, UPD, CMP and EMIT; idx is the neuron currently being processed.
REQ-010 IDLE: on tick=1, SHALL go to UPD with idx=0; busy=1 in every state except IDLE.
REQ-011 UPD (1 cycle): SHALL compute sum = u - (u>>LEAK_SHIFT) + cur[idx] at 9-bit width, saturated to 255.
- If sum >= V_TH: spike=1 and u[idx] <= 0.
- Otherwise: spike=0 and u[idx] <= sum.
- The cur value used is the one registered before this cycle; a same-cycle write is not seen.
REQ-012 CMP (1 cycle): SHALL compute d = |u[idx] - last[idx]|.
- If d >= DELTA_TH or spike=1: go to EMIT.
- Otherwise: advance.
REQ-013 EMIT: SHALL assert evt_valid with evt_idx, evt_delta, evt_up and evt_spike, all held stable until evt_valid && evt_ready.
- At the handshake edge: last[idx] <= u[idx], then advance.
REQ-014 Advance: if idx == N_NEUR-1, SHALL go to IDLE; otherwise SHALL go to UPD with idx+1.
REQ-015 Sweep length SHALL be 2*N_NEUR cycles plus one cycle per event with evt_ready=1, plus stall cycles.
REQ-016 Tick while busy SHALL be ignored (no restart, no queuing) and SHALL set overrun=1; overrun clears only on rst.
REQ-017 Tick in the same cycle the FSM returns to IDLE SHALL count as busy, per REQ-016.
REQ-018 evt_valid SHALL be 0 outside EMIT; evt_* outputs SHALL be 0 when evt_valid=0.
REQ-019 last[i] SHALL update only on an accepted event; u[i] SHALL update only in UPD.

Reset
REQ-020 On rst=1 at an edge, SHALL go to IDLE and clear all cur, u and last entries, overrun and idx.
- Outputs reset to: evt_valid=0, evt_idx=0, evt_delta=0, evt_up=0, evt_spike=0, busy=0, overrun=0.
REQ-021 Reset mid-sweep or mid-EMIT SHALL abort without delivering the pending event; rst SHALL take priority over tick and cur_we.

Verification
REQ-022 The bench SHALL cover these scenarios, with default parameters and evt_ready=1 unless stated:
- Reset: assert rst for 2 cycles, then hold idle -> all outputs 0; busy stays 0 with no tick.
- Single event: cur[0]=60, one tick -> one event (idx=0, delta=60, up=1, spike=0); busy high for 9 cycles.
- Below-threshold accumulation: cur[0]=60, ticks 2, 3 and 4 -> u0 = 90, 105, 113; no event on ticks 2 and 3; tick 4 gives event delta=53, up=1.
- Spike: cur[1]=255, tick -> sum saturates to 255 >= 200; event (idx=1, spike=1, delta=0); u1=0.
- Backpressure and overrun: event pending with evt_ready=0 for 5 cycles; pulse tick meanwhile -> evt_* stable, no restart, overrun=1; release evt_ready -> sweep completes.
- Reset mid-EMIT: rst while evt_valid=1 -> next cycle evt_valid=0 and busy=0; all u, last and cur entries are 0.
